mac_operand_loader: RTL and testbench
=====================================

MAC_OPERAND_LOADER -- requirements
Module: mac_operand_loader

Interface
REQ-001 SHALL have parameter LANES, default 9: number of image/weight lanes per frame; only 9 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 8 bits: operand byte stream.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-007 SHALL have port in_keep_w, input, 1 bit: keep the stored weights; sampled only with the first byte of a frame.
REQ-008 SHALL have port image_out, output, 72 bits: 9 lanes of 8-bit image data; lane 0 is [71:64].
REQ-009 SHALL have port weight_out, output, 36 bits: 9 lanes of 4-bit SD4 weights; lane 0 is [35:32].
REQ-010 SHALL have port exp_bias_out, output, 5 bits: exponent bias.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): handshake for the output operand set.

Function
REQ-012 SHALL accept a frame of 15 bytes in this order:
- 9 image bytes; byte k goes to lane k.
- 5 weight bytes; byte j high nibble goes to lane 2j, low nibble to lane 2j+1; byte 4 low nibble is ignored.
- 1 exp byte; bits [4:0] are used and bits [7:5] are ignored.
REQ-013 SHALL assemble each frame into shadow registers using the states IMG, WGT, EXP and FULL, with a 4-bit byte counter.
REQ-014 SHALL use these state transitions:
- IMG to WGT after image byte 8.
- WGT to EXP after weight byte 4.
- EXP to FULL on the exp byte.
REQ-015 SHALL drive in_ready high in IMG, WGT and EXP, and low in FULL (combinational from state).
REQ-016 SHALL, in FULL, copy the shadow registers to the outputs when (!out_valid || out_ready), then set out_valid=1, counter=0 and state=IMG.
REQ-017 SHALL raise out_valid exactly one cycle after the cycle in which the exp byte is accepted, provided the output is empty.
REQ-018 SHALL hold image_out, weight_out and exp_bias_out stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on out_ready when no transfer occurs in the same cycle; on a simultaneous transfer and out_ready, new data replaces the old and out_valid stays 1.
REQ-020 SHALL keep assembling the next frame while the current output awaits out_ready (double buffering); it stalls only in FULL.
REQ-021 SHALL leave shadow contents unchanged when in_valid is low; no state or counter change occurs.

Reset
REQ-022 SHALL, while rst_n=0, clear image_out, weight_out, exp_bias_out, out_valid, all shadow registers and the counter, and set state=IMG.
REQ-023 SHALL discard any partial frame on reset assertion mid-frame; the first byte after deassertion is image byte 0.
REQ-024 SHALL present in_ready=1 in the first cycle after reset deassertion.

Configuration
REQ-025 SHALL, with WEIGHT_KEEP_EN defined, treat in_keep_w=1 on image byte 0 as follows:
- transition IMG to FULL after image byte 8;
- skip the weight and exp bytes;
- reuse the previously stored weights and exp bias.
REQ-026 SHALL, with WEIGHT_KEEP_EN undefined, ignore in_keep_w, so every frame is 15 bytes.
REQ-027 SHALL, with WEIGHT_KEEP_EN defined, reuse the all-zero reset values if in_keep_w=1 is given after reset with no prior load.

Structure
REQ-028 SHALL place LANES, IMG_W=8, WGT_W=4, EXP_W=5 and the state enum (IMG, WGT, EXP, FULL) in shared package mac_pkg.
REQ-029 SHALL be a single module with no sub-module; the byte-to-lane unpacking is inline.

Verification
REQ-030 Frame test:
- Stimulus: bytes 9E 0C 7A 5A E9 D3 F0 87 F9, 48 40 3B BE A5, 0E.
- Response: image_out=72'h9E0C7A5AE9D3F087F9, weight_out=36'h48403BBEA, exp_bias_out=5'h0E; out_valid rises 1 cycle after the last byte.
REQ-031 Backpressure test:
- Stimulus: out_ready=0; send frame 1, then a full frame 2.
- Response: in_ready=0 in FULL; outputs hold frame 1; one cycle after out_ready=1, frame 2 appears with out_valid continuously 1.
REQ-032 Gapped input test:
- Stimulus: in_valid toggling every other cycle across a whole frame.
- Response: same outputs as REQ-030.
REQ-033 Reset test:
- Stimulus: rst_n pulsed low after image byte 4.
- Response: all outputs are 0 and out_valid=0; a following full frame loads correctly.
REQ-034 Keep-weights test (WEIGHT_KEEP_EN):
- Stimulus: after REQ-030, 9 image bytes 01..09 with in_keep_w=1.
- Response: image_out=72'h010203040506070809, weight_out=36'h48403BBEA, exp_bias_out=5'h0E.
REQ-035 Keep-weights test (no WEIGHT_KEEP_EN):
- Stimulus: same as REQ-034.
- Response: no output until 6 more bytes arrive.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC operand loader.
package mac_pkg;

   localparam int LANES = 9;
   localparam int IMG_W = 8;
   localparam int WGT_W = 4;
   localparam int EXP_W = 5;

   typedef enum logic [1:0] {
      IMG  = 2'd0,
      WGT  = 2'd1,
      EXP  = 2'd2,
      FULL = 2'd3
   } mac_state_e;

endpackage

// File: rtl/mac_operand_loader.sv
// Unpacks a 15-byte operand frame into image/weight/exp-bias shadow registers and hands them
// off double-buffered. Define WEIGHT_KEEP_EN to let a 9-byte frame reuse the stored weights.
module mac_operand_loader
   import mac_pkg::*;
#(
   parameter int LANES = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_keep_w,
   output logic [LANES*IMG_W-1:0]   image_out,
   output logic [LANES*WGT_W-1:0]   weight_out,
   output logic [EXP_W-1:0]         exp_bias_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output mac_state_e               fsm_state
);

   // Handshakes: a byte moves when in_valid && in_ready on a rising edge; an operand set
   // is consumed when out_valid && out_ready on a rising edge. out_valid never drops
   // without out_ready, and the outputs do not change while out_valid && !out_ready.

   localparam int WGT_BYTES = (LANES + 1) / 2;

   mac_state_e               state;
   logic [3:0]               cnt;
   logic [LANES*IMG_W-1:0]   img_sh;
   logic [LANES*WGT_W-1:0]   wgt_sh;
   logic [EXP_W-1:0]         exp_sh;
   logic                     accept;
   logic                     load;
   logic                     last_img;
   logic                     last_wgt;
   logic                     keep_now;

   assign in_ready  = (state != FULL);
   assign accept    = in_valid && in_ready;
   assign load      = (state == FULL) && (!out_valid || out_ready);
   assign last_img  = (cnt == 4'(LANES - 1));
   assign last_wgt  = (cnt == 4'(WGT_BYTES - 1));
   assign fsm_state = state;

`ifdef WEIGHT_KEEP_EN
   logic keep_q;

   // The keep request only counts on image byte 0; later bytes use the latched copy.
   assign keep_now = (cnt == 4'd0) ? in_keep_w : keep_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keep_q <= 1'b0;
      end else if (accept && (state == IMG) && (cnt == 4'd0)) begin
         keep_q <= in_keep_w;
      end
   end
`else
   logic unused_keep;

   assign keep_now    = 1'b0;
   assign unused_keep = in_keep_w;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IMG;
         cnt          <= '0;
         img_sh       <= '0;
         wgt_sh       <= '0;
         exp_sh       <= '0;
         image_out    <= '0;
         weight_out   <= '0;
         exp_bias_out <= '0;
         out_valid    <= 1'b0;
      end else begin
         if (load) begin
            image_out    <= img_sh;
            weight_out   <= wgt_sh;
            exp_bias_out <= exp_sh;
            out_valid    <= 1'b1;
            cnt          <= '0;
            state        <= IMG;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (accept) begin
            case (state)
               IMG: begin
                  for (int k = 0; k < LANES; k++) begin
                     if (cnt == 4'(k)) begin
                        img_sh[IMG_W*(LANES-1-k) +: IMG_W] <= in_data;
                     end
                  end
                  if (last_img) begin
                     cnt   <= '0;
                     state <= keep_now ? FULL : WGT;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               WGT: begin
                  // Even lanes take the high nibble of byte lane/2, odd lanes the low nibble;
                  // the low nibble of the last weight byte has no lane.
                  for (int l = 0; l < LANES; l++) begin
                     if (cnt == 4'(l / 2)) begin
                        wgt_sh[WGT_W*(LANES-1-l) +: WGT_W] <= (l % 2 == 0) ? in_data[7:4]
                                                                           : in_data[3:0];
                     end
                  end
                  if (last_wgt) begin
                     cnt   <= '0;
                     state <= EXP;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               EXP: begin
                  exp_sh <= in_data[EXP_W-1:0];
                  cnt    <= '0;
                  state  <= FULL;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: directed steps, then randomized frames scored against a
// frame-level model. Build with WEIGHT_KEEP_EN defined to cover weight reuse.
module tb_mac_operand_loader;
   import mac_pkg::*;

   localparam int W     = 72 + 36 + 5;
   localparam int BOUND = 400;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_keep_w = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [71:0]  image_out;
   logic [35:0]  weight_out;
   logic [4:0]   exp_bias_out;
   mac_state_e   fsm_state;

   int           total = 0;
   int           bad = 0;
   logic [W-1:0] exp_q[$];
   logic [7:0]   fb [15];
   logic [35:0]  ref_w = '0;
   logic [4:0]   ref_e = '0;
   int           ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

   mac_operand_loader #(.LANES(9)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_keep_w    (in_keep_w),
      .image_out    (image_out),
      .weight_out   (weight_out),
      .exp_bias_out (exp_bias_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fsm_state    (fsm_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom);
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: every consumed operand set must match the oldest expected one.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_unexpected observed=%0h expected=none",
                   {image_out, weight_out, exp_bias_out});
         end else begin
            chk("sb_out", 128'({image_out, weight_out, exp_bias_out}), 128'(exp_q.pop_front()));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic k, input logic gap);
      int guard;
      guard = 0;
      @(negedge clk);
      if (gap) @(negedge clk);
      while (!in_ready && guard < BOUND) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= BOUND) begin
         total++;
         bad++;
         $error("FAIL in_ready_wait observed=0 expected=1");
      end
      in_data   = b;
      in_keep_w = k;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data   = 8'($urandom);
      in_keep_w = 1'($urandom);
   endtask

   // Model: image is the first 9 bytes in order; a 15-byte frame replaces the stored weights
   // (5 bytes, last low nibble dropped) and the exp bias (low 5 bits); a 9-byte frame reuses them.
   task automatic model_push(input int n);
      logic [71:0] img;
      img = '0;
      for (int k = 0; k < 9; k++) img = {img[63:0], fb[k]};
      if (n == 15) begin
         ref_w = {fb[9], fb[10], fb[11], fb[12], fb[13][7:4]};
         ref_e = fb[14][4:0];
      end
      exp_q.push_back({img, ref_w, ref_e});
   endtask

   // gapmode 0: back-to-back, 1: idle cycle before every byte, 2: random idles
   task automatic send_frame(input int n, input logic keep, input int gapmode);
      for (int i = 0; i < n; i++) begin
         logic g;
         g = (gapmode == 1) || (gapmode == 2 && $urandom_range(0, 3) == 0);
         send_byte(fb[i], (i == 0) ? keep : 1'($urandom), g);
      end
      model_push(n);
   endtask

   task automatic load_ref_bytes();
      logic [119:0] rb;
      rb = 120'h9E0C7A5AE9D3F087F948403BBEA50E;
      for (int k = 0; k < 15; k++) fb[k] = rb[119-8*k -: 8];
   endtask

   task automatic fill_random();
      for (int k = 0; k < 15; k++) fb[k] = 8'($urandom);
   endtask

   task automatic chk_out(input string tag, input logic [71:0] img, input logic [35:0] w,
                          input logic [4:0] e);
      chk({tag, "_image"},  128'(image_out),    128'(img));
      chk({tag, "_weight"}, 128'(weight_out),   128'(w));
      chk({tag, "_exp"},    128'(exp_bias_out), 128'(e));
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      ref_w = '0;
      ref_e = '0;
      chk_out(tag, 72'h0, 36'h0, 5'h0);
      chk({tag, "_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_state"}, 128'(fsm_state), 128'(IMG));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
   endtask

   initial begin
      logic [W-1:0] f1;
      logic [W-1:0] f2;
      int           n;
      logic         kp;
      int           guard;

      // Power-on reset
      repeat (3) @(negedge clk);
      chk_out("por", 72'h0, 36'h0, 5'h0);
      chk("por_valid", 128'(out_valid), 128'(0));
      chk("por_state", 128'(fsm_state), 128'(IMG));
      rst_n = 1'b1;
      #1;
      chk("por_in_ready", 128'(in_ready), 128'(1));

      // Reference frame, one byte per cycle
      load_ref_bytes();
      send_frame(15, 1'b0, 0);
      @(negedge clk);
      chk("frm_valid_early", 128'(out_valid), 128'(0));
      chk("frm_full_ready", 128'(in_ready), 128'(0));
      chk("frm_full_state", 128'(fsm_state), 128'(FULL));
      @(negedge clk);
      chk("frm_valid", 128'(out_valid), 128'(1));
      chk_out("frm", 72'h9E0C7A5AE9D3F087F9, 36'h48403BBEA, 5'h0E);

      // Backpressure: frame 1 waits at the output while frame 2 fills the shadows
      ready_mode = 0;
      fill_random();
      send_frame(15, 1'b0, 0);
      f1 = exp_q[$];
      guard = 0;
      while (!out_valid && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk("bp_first_valid", 128'(out_valid), 128'(1));
      fill_random();
      send_frame(15, 1'b0, 2);
      f2 = exp_q[$];
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 128'(in_ready), 128'(0));
         chk("bp_state", 128'(fsm_state), 128'(FULL));
         chk("bp_hold_valid", 128'(out_valid), 128'(1));
         chk("bp_hold_data", 128'({image_out, weight_out, exp_bias_out}), 128'(f1));
      end
      ready_mode = 1;
      @(negedge clk);
      chk("bp_valid_pre", 128'(out_valid), 128'(1));
      @(negedge clk);
      chk("bp_valid_cont", 128'(out_valid), 128'(1));
      chk("bp_frame2", 128'({image_out, weight_out, exp_bias_out}), 128'(f2));
      @(negedge clk);
      chk("bp_valid_drop", 128'(out_valid), 128'(0));

      // Reset after image byte 4, then a gapped reference frame
      load_ref_bytes();
      for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0, 1'b0);
      do_reset("midrst");
      send_frame(15, 1'b0, 1);
      @(negedge clk);
      chk("gap_valid_early", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("gap_valid", 128'(out_valid), 128'(1));
      chk_out("gap", 72'h9E0C7A5AE9D3F087F9, 36'h48403BBEA, 5'h0E);

      // Keep-weights request on a 9-byte image frame
      for (int k = 0; k < 15; k++) fb[k] = (k < 9) ? 8'(k + 1) : 8'($urandom);
`ifdef WEIGHT_KEEP_EN
      send_frame(9, 1'b1, 0);
      @(negedge clk);
      chk("keep_valid_early", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("keep_valid", 128'(out_valid), 128'(1));
      chk_out("keep", 72'h010203040506070809, 36'h48403BBEA, 5'h0E);
      do_reset("keeprst");
      fill_random();
      send_frame(9, 1'b1, 0);
      @(negedge clk);
      @(negedge clk);
      chk("keep0_valid", 128'(out_valid), 128'(1));
      chk("keep0_weight", 128'(weight_out), 128'(0));
      chk("keep0_exp", 128'(exp_bias_out), 128'(0));
`else
      for (int i = 0; i < 9; i++) send_byte(fb[i], (i == 0), 1'b0);
      repeat (4) begin
         @(negedge clk);
         chk("nokeep_no_valid", 128'(out_valid), 128'(0));
      end
      chk("nokeep_state", 128'(fsm_state), 128'(WGT));
      chk("nokeep_in_ready", 128'(in_ready), 128'(1));
      for (int i = 9; i < 15; i++) send_byte(fb[i], 1'($urandom), 1'b0);
      model_push(15);
      @(negedge clk);
      chk("nokeep_valid_early", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("nokeep_valid", 128'(out_valid), 128'(1));
      chk("nokeep_image", 128'(image_out), 128'(72'h010203040506070809));
`endif

      // Randomized frames with random idles and random output backpressure
      ready_mode = 2;
      for (int f = 0; f < 30; f++) begin
         fill_random();
         kp = 1'($urandom);
`ifdef WEIGHT_KEEP_EN
         n = kp ? 9 : 15;
`else
         n = 15;
`endif
         send_frame(n, kp, 2);
      end
      @(negedge clk);
      ready_mode = 1;
      guard = 0;
      while (exp_q.size() != 0 && guard < BOUND) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_empty", 128'(exp_q.size()), 128'(0));
      @(negedge clk);
      @(negedge clk);
      chk("final_idle", 128'(out_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
